// File: rtl/button_event.sv
// Button event generator: press/release pulses, long-press detection and a press counter.
// Define BUTTON_REPEAT_EN to add auto-repeat pulses while a long press is held.
module button_event #(
   parameter int CLK_FREQUENCY  = 100_000_000,
   parameter int LONG_TIME_US   = 1_000_000,
   parameter int REPEAT_TIME_US = 200_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       debounced,
   output logic       press,
   output logic       release_pulse,
   output logic       long_press,
   output logic       repeat_pulse,
   output logic       held,
   output logic [7:0] press_count
);

   localparam int LONG_CLOCKS = CLK_FREQUENCY / 1_000_000 * LONG_TIME_US;
   localparam int HOLD_W      = $clog2(LONG_CLOCKS + 1);
   localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CLOCKS - 1);

   typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;

   state_t            state, state_nxt;
   logic              debounced_d;
   logic              rise, fall;
   logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
   logic              press_nxt, release_nxt, long_nxt, held_nxt;

`ifdef BUTTON_REPEAT_EN
   localparam int REPEAT_CLOCKS = CLK_FREQUENCY / 1_000_000 * REPEAT_TIME_US;
   localparam int REP_W         = $clog2(REPEAT_CLOCKS + 1);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CLOCKS - 1);

   logic [REP_W-1:0] rep_cnt, rep_cnt_nxt;
   logic             repeat_nxt;
`endif

   assign rise = debounced & ~debounced_d;
   assign fall = ~debounced & debounced_d;

   // debounced_d resets high so a button held through reset is not seen as a rise
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         debounced_d   <= 1'b1;
         hold_cnt      <= '0;
         press         <= 1'b0;
         release_pulse <= 1'b0;
         long_press    <= 1'b0;
         held          <= 1'b0;
         press_count   <= 8'd0;
`ifdef BUTTON_REPEAT_EN
         rep_cnt       <= '0;
         repeat_pulse  <= 1'b0;
`endif
      end else begin
         state         <= state_nxt;
         debounced_d   <= debounced;
         hold_cnt      <= hold_cnt_nxt;
         press         <= press_nxt;
         release_pulse <= release_nxt;
         long_press    <= long_nxt;
         held          <= held_nxt;
         press_count   <= press_count + 8'(press_nxt);
`ifdef BUTTON_REPEAT_EN
         rep_cnt       <= rep_cnt_nxt;
         repeat_pulse  <= repeat_nxt;
`endif
      end
   end

   // A fall is tested before any threshold so it always wins a tie
   always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = hold_cnt;
      press_nxt    = 1'b0;
      release_nxt  = 1'b0;
      long_nxt     = 1'b0;
`ifdef BUTTON_REPEAT_EN
      rep_cnt_nxt  = rep_cnt;
      repeat_nxt   = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (rise) begin
               state_nxt    = HELD;
               hold_cnt_nxt = '0;
               press_nxt    = 1'b1;
            end
         end
         HELD: begin
            if (fall) begin
               state_nxt   = IDLE;
               release_nxt = 1'b1;
            end else if (debounced) begin
               if (hold_cnt == LONG_LAST) begin
                  state_nxt = LONG;
                  long_nxt  = 1'b1;
`ifdef BUTTON_REPEAT_EN
                  rep_cnt_nxt = '0;
`endif
               end else begin
                  hold_cnt_nxt = hold_cnt + HOLD_W'(1);
               end
            end
         end
         LONG: begin
            if (fall) begin
               state_nxt   = IDLE;
               release_nxt = 1'b1;
            end
`ifdef BUTTON_REPEAT_EN
            else if (debounced) begin
               if (rep_cnt == REP_LAST) begin
                  repeat_nxt  = 1'b1;
                  rep_cnt_nxt = '0;
               end else begin
                  rep_cnt_nxt = rep_cnt + REP_W'(1);
               end
            end
`endif
         end
         default: state_nxt = IDLE;
      endcase
      held_nxt = (state_nxt != IDLE);
   end

`ifndef BUTTON_REPEAT_EN
   assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_event.sv
// Scoreboard bench for button_event: stimulus queues expected pulse events,
// a negedge monitor pops and compares them as the DUT emits pulses.
module tb_button_event;

   localparam int EV_PRESS   = 0;
   localparam int EV_LONG    = 1;
   localparam int EV_REPEAT  = 2;
   localparam int EV_RELEASE = 3;
   localparam int LONGC      = 20;
   localparam int REPC       = 5;

   typedef struct {
      int         kind;
      int         cyc;
      logic [7:0] cnt;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       debounced;
   logic       press, release_pulse, long_press, repeat_pulse, held;
   logic [7:0] press_count;

   ev_t        q[$];
   int         cyc = 0;
   int         errors = 0;
   int         checks = 0;
   int         held_from = 0;
   int         held_to = 0;
   logic [7:0] model_cnt = 8'd0;
   string      names[4] = '{"press", "long_press", "repeat", "release"};

   button_event #(
      .CLK_FREQUENCY (1_000_000),
      .LONG_TIME_US  (20),
      .REPEAT_TIME_US(5)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .debounced    (debounced),
      .press        (press),
      .release_pulse(release_pulse),
      .long_press   (long_press),
      .repeat_pulse (repeat_pulse),
      .held         (held),
      .press_count  (press_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int kind, input int c, input logic [7:0] cnt);
      ev_t e;
      e.kind = kind;
      e.cyc  = c;
      e.cnt  = cnt;
      q.push_back(e);
   endtask

   task automatic check_event(input int kind);
      ev_t e;
      checks++;
      if (q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_%s: got pulse at cycle %0d, expected none", names[kind], cyc);
      end else begin
         e = q.pop_front();
         if (e.kind != kind || e.cyc != cyc || (kind == EV_PRESS && press_count !== e.cnt)) begin
            errors++;
            $display("FAIL event: got %s@%0d cnt=%0d expected %s@%0d cnt=%0d",
                     names[kind], cyc, press_count, names[e.kind], e.cyc, e.cnt);
         end
      end
   endtask

   // Monitor: pulses against the scoreboard, held against the expected window
   always @(negedge clk) begin
      logic [3:0] p;
      p = {release_pulse, repeat_pulse, long_press, press};
      for (int i = 0; i < 4; i++)
         if (p[i] === 1'b1) check_event(i);
      chk("held_level", {31'd0, held}, {31'd0, (cyc >= held_from && cyc < held_to)});
      if (press === 1'b1 && release_pulse === 1'b1) chk("press_release_exclusive", 32'd1, 32'd0);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Hold the button for n sampled cycles and queue every pulse that must follow
   task automatic hold(input int n);
      int k;
      k = cyc + 1;
      model_cnt = model_cnt + 8'd1;
      push(EV_PRESS, k, model_cnt);
      if (n > LONGC) push(EV_LONG, k + LONGC, 8'd0);
`ifdef BUTTON_REPEAT_EN
      for (int j = 1; LONGC + REPC * j < n; j++) push(EV_REPEAT, k + LONGC + REPC * j, 8'd0);
`endif
      push(EV_RELEASE, k + n, 8'd0);
      held_from = k;
      held_to   = k + n;
      debounced = 1'b1;
      repeat (n) step();
      debounced = 1'b0;
      repeat (3) step();
   endtask

   initial begin
      int k;
      rst = 1'b1;
      debounced = 1'b1;
      #2 rst = 1'b0;
      repeat (3) step();
      chk("reset_outputs", {19'd0, press, release_pulse, long_press, repeat_pulse, held, press_count}, 32'd0);

      // Button held through reset: neither its presence nor its release produces a pulse
      rst = 1'b1;
      repeat (5) step();
      debounced = 1'b0;
      repeat (5) step();
      chk("no_press_after_reset", {24'd0, press_count}, 32'd0);

      hold(10);
      chk("count_after_short", {24'd0, press_count}, 32'd1);
      hold(40);
      hold(LONGC);
      hold(LONGC + 1);
      chk("count_after_four", {24'd0, press_count}, 32'd4);

      // Reset pulled low mid-hold aborts with no release
      k = cyc + 1;
      model_cnt = model_cnt + 8'd1;
      push(EV_PRESS, k, model_cnt);
      held_from = k;
      held_to   = 1 << 30;
      debounced = 1'b1;
      repeat (8) step();
      chk("held_mid_hold", {31'd0, held}, 32'd1);
      held_to = cyc;
      rst = 1'b0;
      #1;
      chk("async_reset_outputs", {19'd0, press, release_pulse, long_press, repeat_pulse, held, press_count}, 32'd0);
      model_cnt = 8'd0;
      step();
      step();
      rst = 1'b1;
      repeat (3) step();
      debounced = 1'b0;
      repeat (5) step();
      chk("count_after_abort", {24'd0, press_count}, 32'd0);

      for (int i = 0; i < 256; i++) hold(2);
      chk("count_wrap", {24'd0, press_count}, 32'd0);

      repeat (5) step();
      chk("scoreboard_drained", q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
